// File: rtl/ob_cmd_mux_pkg.sv
// ob_cmd_mux_pkg: ob command/response types and channel-mux defaults
package ob_cmd_mux_pkg;
  localparam int UID_W = 16;
  localparam int N_CH_DFLT = 4;
  localparam int DEPTH_DFLT = 4;
  typedef logic [UID_W-1:0] uid_t;
  typedef logic [$clog2(N_CH_DFLT)-1:0] chan_t;
  typedef enum logic {SIDE_BID, SIDE_ASK} side_t;
  typedef enum logic [1:0] {RSP_ACK, RSP_TRADE, RSP_REJECT, RSP_CANCEL} rsp_kind_t;
  typedef struct packed {
    uid_t uid;
    side_t side;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;
  typedef struct packed {
    uid_t uid;
    rsp_kind_t kind;
    logic [15:0] price;
    logic [15:0] qty;
  } rsp_t;
  function automatic uid_t mk_uid(int ch, int ch_w, int seq);
    return (uid_t'(ch) << (UID_W - ch_w)) | uid_t'(seq % (1 << (UID_W - ch_w)));
  endfunction
endpackage

// File: rtl/ob_cmd_mux_if.sv
// ob_cmd_mux_if: client command/response and ob-side bundle of the channel mux
interface ob_cmd_mux_if import ob_cmd_mux_pkg::*; #(
  parameter int N_CH = N_CH_DFLT
);
  logic [N_CH-1:0] ch_cmd_vld;
  cmd_t ch_cmd [N_CH];
  logic [N_CH-1:0] ch_cmd_full;
  logic [N_CH-1:0] ch_rsp_vld;
  rsp_t ch_rsp;
  logic [N_CH-1:0] ch_rsp_accept;
  logic ob_cmd_vld_r;
  cmd_t ob_cmd_r;
  logic ob_cmd_full_r;
  logic ob_rsp_vld;
  rsp_t ob_rsp;
  logic ob_rsp_accept;
  logic [N_CH-1:0] err_uid_r;
  logic [31:0] issue_cnt_r [N_CH];
  modport slave (
    input ch_cmd_vld, ch_cmd, ch_rsp_accept, ob_cmd_full_r, ob_rsp_vld, ob_rsp,
    output ch_cmd_full, ch_rsp_vld, ch_rsp, ob_cmd_vld_r, ob_cmd_r, ob_rsp_accept,
    err_uid_r, issue_cnt_r
  );
  modport master (
    output ch_cmd_vld, ch_cmd, ch_rsp_accept, ob_cmd_full_r, ob_rsp_vld, ob_rsp,
    input ch_cmd_full, ch_rsp_vld, ch_rsp, ob_cmd_vld_r, ob_cmd_r, ob_rsp_accept,
    err_uid_r, issue_cnt_r
  );
endinterface

// File: rtl/ob_cmd_mux_fifo.sv
// ob_cmd_fifo: DEPTH-deep command FIFO with registered full/empty flags
module ob_cmd_fifo import ob_cmd_mux_pkg::*; #(
  parameter int DEPTH = DEPTH_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full_r,
  output logic empty_r
);
  localparam int AW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push && !full_r;
  assign do_pop = pop && !empty_r;
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout = mem[rd_q];
  // pointers, occupancy and flags; flags come from next occupancy so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      full_r <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
      full_r <= cnt_d == (AW+1)'(DEPTH);
      empty_r <= cnt_d == '0;
    end
  end
  // storage is not reset; contents are only visible once written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end
endmodule

// File: rtl/ob_cmd_mux.sv
// ob_cmd_mux: N-channel command ingress with round-robin issue to ob and uid-routed response egress
module ob_cmd_mux import ob_cmd_mux_pkg::*; #(
  parameter int N_CH = N_CH_DFLT,
  parameter int DEPTH = DEPTH_DFLT,
  localparam int CH_W = $clog2(N_CH)
) (
  input logic clk,
  input logic rst_n,
  ob_cmd_mux_if.slave bus
);
  logic [N_CH-1:0] push, pop, full, empty, uid_bad, err_q;
  cmd_t head [N_CH];
  logic [CH_W-1:0] rr_q, pick, idx, rsp_ch;
  logic found, issue, rsp_ok, vld_q;
  cmd_t cmd_q;
  logic [31:0] cnt_q [N_CH];
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign uid_bad[i] = bus.ch_cmd[i].uid[UID_W-1 -: CH_W] != CH_W'(i);
    assign push[i] = bus.ch_cmd_vld[i] && !full[i] && !uid_bad[i];
    ob_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push[i]),
      .pop(pop[i]),
      .din(bus.ch_cmd[i]),
      .dout(head[i]),
      .full_r(full[i]),
      .empty_r(empty[i])
    );
  end
  // first non-empty FIFO at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    pick = rr_q;
    idx = rr_q;
    for (int k = 0; k < N_CH; k++) begin
      idx = CH_W'((int'(rr_q) + k) % N_CH);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign issue = found && !bus.ob_cmd_full_r;
  assign pop = issue ? N_CH'(1) << pick : '0;
  // issue register, pointer advance past the winner, per-channel issue counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      cmd_q <= '0;
      rr_q <= '0;
      for (int n = 0; n < N_CH; n++) cnt_q[n] <= '0;
    end else begin
      vld_q <= issue;
      if (issue) begin
        cmd_q <= head[pick];
        rr_q <= (pick == CH_W'(N_CH - 1)) ? '0 : pick + CH_W'(1);
        cnt_q[pick] <= cnt_q[pick] + 32'd1;
      end
    end
  end
  // sticky flag for any presented command whose uid names another channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else err_q <= err_q | (bus.ch_cmd_vld & uid_bad);
  end
  assign bus.ob_cmd_vld_r = vld_q;
  assign bus.ob_cmd_r = cmd_q;
  assign bus.ch_cmd_full = full;
  assign bus.err_uid_r = err_q;
  assign bus.issue_cnt_r = cnt_q;
  assign rsp_ch = bus.ob_rsp.uid[UID_W-1 -: CH_W];
  assign rsp_ok = int'(rsp_ch) < N_CH;
  assign bus.ch_rsp = bus.ob_rsp;
  assign bus.ch_rsp_vld = (rst_n && rsp_ok && bus.ob_rsp_vld) ? N_CH'(1) << rsp_ch : '0;
  assign bus.ob_rsp_accept = rst_n && (!rsp_ok || bus.ch_rsp_accept[rsp_ch]);
endmodule

// File: tb/tb_ob_cmd_mux.sv
// tb_ob_cmd_mux: randomized and directed bench for ob_cmd_mux against a queue-based model
module tb_ob_cmd_mux;
  import ob_cmd_mux_pkg::*;
  localparam int N = 4;
  localparam int D = 4;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int seq = 0;
  cmd_t mq [N][$];
  int rr;
  logic [31:0] mcnt [N];
  logic [N-1:0] merr;
  ob_cmd_mux_if #(.N_CH(N)) bus();
  ob_cmd_mux #(.N_CH(N), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int top_ch(uid_t u);
    return int'(u >> (UID_W - CW));
  endfunction
  function automatic cmd_t mk_cmd(int ch);
    cmd_t c;
    seq++;
    c.uid = mk_uid(ch, CW, seq);
    c.side = $urandom_range(0, 1) ? SIDE_ASK : SIDE_BID;
    c.price = 16'($urandom);
    c.qty = 16'($urandom);
    return c;
  endfunction
  task automatic idle();
    bus.ch_cmd_vld = '0;
    bus.ob_cmd_full_r = 1'b0;
    bus.ob_rsp_vld = 1'b0;
    bus.ob_rsp = '0;
    bus.ch_rsp_accept = '1;
  endtask
  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      mcnt[i] = '0;
    end
    rr = 0;
    merr = '0;
  endtask
  task automatic step();
    int ch;
    bit found;
    cmd_t exp_cmd;
    logic [N-1:0] fpre, ev;
    #1;
    ch = top_ch(bus.ob_rsp.uid);
    ev = bus.ob_rsp_vld ? N'(1) << ch : '0;
    chk("rsp_vld", 64'(bus.ch_rsp_vld), 64'(ev));
    chk("rsp_accept", 64'(bus.ob_rsp_accept), 64'(bus.ch_rsp_accept[ch]));
    if (bus.ob_rsp_vld) chk("rsp_data", 64'(bus.ch_rsp), 64'(bus.ob_rsp));
    for (int i = 0; i < N; i++) fpre[i] = mq[i].size() == D;
    found = 0;
    exp_cmd = '0;
    if (!bus.ob_cmd_full_r) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (!found && mq[c].size() > 0) begin
          found = 1;
          exp_cmd = mq[c].pop_front();
          mcnt[c]++;
          rr = (c + 1) % N;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.ch_cmd_vld[i]) begin
        if (top_ch(bus.ch_cmd[i].uid) != i) merr[i] = 1'b1;
        else if (!fpre[i]) mq[i].push_back(bus.ch_cmd[i]);
      end
    end
    @(posedge clk);
    #1;
    chk("cmd_vld", 64'(bus.ob_cmd_vld_r), 64'(found));
    if (found) chk("cmd_data", 64'(bus.ob_cmd_r), 64'(exp_cmd));
    for (int i = 0; i < N; i++) begin
      chk("ch_full", 64'(bus.ch_cmd_full[i]), 64'(mq[i].size() == D));
      chk("issue_cnt", 64'(bus.issue_cnt_r[i]), 64'(mcnt[i]));
    end
    chk("err_uid", 64'(bus.err_uid_r), 64'(merr));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cmd_vld", 64'(bus.ob_cmd_vld_r), 64'(0));
    chk("rst_cmd", 64'(bus.ob_cmd_r), 64'(0));
    chk("rst_full", 64'(bus.ch_cmd_full), 64'(0));
    chk("rst_err", 64'(bus.err_uid_r), 64'(0));
    chk("rst_rsp_vld", 64'(bus.ch_rsp_vld), 64'(0));
    for (int i = 0; i < N; i++) chk("rst_cnt", 64'(bus.issue_cnt_r[i]), 64'(0));
    model_clear();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rsp_t r;
    int pushed [N];
    int exp_ch;
    for (int i = 0; i < N; i++) bus.ch_cmd[i] = '0;
    idle();
    #2;
    do_reset();
    // reset mid-burst, then push-to-issue latency
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.ch_cmd_vld[i] = 1'b1;
        bus.ch_cmd[i] = mk_cmd(i);
      end
      step();
    end
    r = '0;
    r.uid = mk_uid(1, CW, 5);
    bus.ob_rsp = r;
    bus.ob_rsp_vld = 1'b1;
    do_reset();
    bus.ch_cmd_vld[0] = 1'b1;
    bus.ch_cmd[0] = mk_cmd(0);
    bus.ch_cmd[0].uid = 16'h0001;
    step();
    chk("lat_cycle1", 64'(bus.ob_cmd_vld_r), 64'(0));
    bus.ch_cmd_vld = '0;
    step();
    chk("lat_cycle2", 64'(bus.ob_cmd_vld_r), 64'(1));
    chk("lat_uid", 64'(bus.ob_cmd_r.uid), 64'(16'h0001));
    // fairness: 8 commands per channel issue in strict rotation
    do_reset();
    for (int i = 0; i < N; i++) pushed[i] = 0;
    exp_ch = 0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.ch_cmd_vld[i] = pushed[i] < 8 && mq[i].size() < D;
        bus.ch_cmd[i] = mk_cmd(i);
        if (bus.ch_cmd_vld[i]) pushed[i]++;
      end
      step();
      if (bus.ob_cmd_vld_r) begin
        chk("rr_order", 64'(top_ch(bus.ob_cmd_r.uid)), 64'(exp_ch));
        exp_ch = (exp_ch + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) chk("fair_cnt", 64'(bus.issue_cnt_r[i]), 64'(8));
    // backpressure: 6 pushes into a 4-deep FIFO while ob is full
    do_reset();
    bus.ob_cmd_full_r = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.ch_cmd_vld = '0;
      if (c < 6) begin
        bus.ch_cmd_vld[2] = 1'b1;
        bus.ch_cmd[2] = mk_cmd(2);
      end
      step();
      if (c == 2) chk("bp_full_after3", 64'(bus.ch_cmd_full[2]), 64'(0));
      if (c == 3) chk("bp_full_after4", 64'(bus.ch_cmd_full[2]), 64'(1));
      chk("bp_no_issue", 64'(bus.ob_cmd_vld_r), 64'(0));
    end
    bus.ch_cmd_vld = '0;
    bus.ob_cmd_full_r = 1'b0;
    repeat (6) step();
    chk("bp_issued", 64'(bus.issue_cnt_r[2]), 64'(4));
    // uid check: ch1 presents a uid belonging to ch3
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.ch_cmd_vld[i] = 1'b1;
      bus.ch_cmd[i] = mk_cmd(i == 1 ? 3 : i);
    end
    step();
    bus.ch_cmd_vld = '0;
    repeat (5) step();
    chk("uid_err", 64'(bus.err_uid_r), 64'(4'b0010));
    chk("uid_cnt1", 64'(bus.issue_cnt_r[1]), 64'(0));
    chk("uid_cnt0", 64'(bus.issue_cnt_r[0]), 64'(1));
    chk("uid_cnt3", 64'(bus.issue_cnt_r[3]), 64'(1));
    // egress: channel 2 stalls its response for 5 cycles
    do_reset();
    r = '0;
    r.uid = mk_uid(2, CW, 77);
    r.kind = RSP_TRADE;
    bus.ob_rsp = r;
    bus.ob_rsp_vld = 1'b1;
    bus.ch_rsp_accept = 4'b1011;
    repeat (5) begin
      step();
      chk("eg_hold_vld", 64'(bus.ch_rsp_vld), 64'(4'b0100));
      chk("eg_hold_acc", 64'(bus.ob_rsp_accept), 64'(0));
    end
    bus.ch_rsp_accept = 4'b0100;
    #1;
    chk("eg_accept", 64'(bus.ob_rsp_accept), 64'(1));
    // concurrent push and pop on a full ch0 FIFO
    do_reset();
    bus.ob_cmd_full_r = 1'b1;
    repeat (4) begin
      bus.ch_cmd_vld[0] = 1'b1;
      bus.ch_cmd[0] = mk_cmd(0);
      step();
    end
    chk("cc_full", 64'(bus.ch_cmd_full[0]), 64'(1));
    bus.ob_cmd_full_r = 1'b0;
    repeat (10) begin
      bus.ch_cmd_vld[0] = 1'b1;
      bus.ch_cmd[0] = mk_cmd(0);
      step();
    end
    bus.ch_cmd_vld = '0;
    repeat (6) step();
    chk("cc_cnt0", 64'(bus.issue_cnt_r[0]), 64'(13));
    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.ch_cmd_vld[i] = $urandom_range(0, 9) < 6;
        bus.ch_cmd[i] = mk_cmd(($urandom_range(0, 19) == 0) ? (i + 1) % N : i);
      end
      bus.ob_cmd_full_r = $urandom_range(0, 9) < 3;
      r = '0;
      r.uid = mk_uid($urandom_range(0, N - 1), CW, c);
      r.qty = 16'($urandom);
      bus.ob_rsp = r;
      bus.ob_rsp_vld = 1'($urandom_range(0, 1));
      bus.ch_rsp_accept = 4'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
